// File: rtl/memory_step.sv
// Memory stage: EX/MEM latch, branch resolve, word RAM access, MEM/WB latch.
// Misaligned accesses are squashed and recorded in a sticky fault flag.
module memory_step #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        branch,
    input  logic        regWrite,
    input  logic        memToReg,
    input  logic [31:0] addResult,
    input  logic        zero,
    input  logic [31:0] aluResult,
    input  logic [31:0] reg2Out,
    input  logic [4:0]  muxRegDstOut,
    output logic        pcSrc,
    output logic [31:0] branchTarget,
    output logic        exMemRegWrite,
    output logic [4:0]  exMemWriteReg,
    output logic [31:0] exMemAluResult,
    output logic [31:0] readData,
    output logic [31:0] wbAluResult,
    output logic [4:0]  wbWriteReg,
    output logic        wbRegWrite,
    output logic        wbMemToReg,
    output logic        memFault
);

    typedef struct packed {
        logic        memRead;
        logic        memWrite;
        logic        branch;
        logic        regWrite;
        logic        memToReg;
        logic        zero;
        logic [31:0] addResult;
        logic [31:0] aluResult;
        logic [31:0] reg2Out;
        logic [4:0]  writeReg;
    } ex_mem_t;

    typedef struct packed {
        logic        regWrite;
        logic        memToReg;
        logic [31:0] readData;
        logic [31:0] aluResult;
        logic [4:0]  writeReg;
    } mem_wb_t;

    ex_mem_t           exm_d, exm_q;
    mem_wb_t           mwb_d, mwb_q;
    logic              fault_d, fault_q;
    logic [31:0]       mem [MEM_DEPTH];
    logic [ADDR_W-1:0] idx;
    logic              misal;
    logic              we;
    logic [31:0]       rdata;

    // Flush wins over stall so a squashed slot never survives a freeze.
    always_comb begin
        exm_d = exm_q;
        if (flush) begin
            exm_d = '0;
        end else if (!stall) begin
            exm_d.memRead   = memRead;
            exm_d.memWrite  = memWrite;
            exm_d.branch    = branch;
            exm_d.regWrite  = regWrite;
            exm_d.memToReg  = memToReg;
            exm_d.zero      = zero;
            exm_d.addResult = addResult;
            exm_d.aluResult = aluResult;
            exm_d.reg2Out   = reg2Out;
            exm_d.writeReg  = muxRegDstOut;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exm_q <= '0;
        end else begin
            exm_q <= exm_d;
        end
    end

    assign idx   = exm_q.aluResult[ADDR_W+1:2];
    assign misal = (exm_q.aluResult[1:0] != 2'b00)
                 & (exm_q.memRead | exm_q.memWrite);
    assign we    = exm_q.memWrite & ~misal & ~stall;
    assign rdata = mem[idx];

    // Write only on the edge that retires the MEM cycle, so stalls never repeat it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= exm_q.reg2Out;
        end
    end

    always_comb begin
        mwb_d   = mwb_q;
        fault_d = fault_q | misal;
        if (!stall) begin
            mwb_d.regWrite  = exm_q.regWrite;
            mwb_d.memToReg  = exm_q.memToReg;
            mwb_d.aluResult = exm_q.aluResult;
            mwb_d.writeReg  = exm_q.writeReg;
            mwb_d.readData  = (exm_q.memRead && !misal) ? rdata : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mwb_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            mwb_q   <= mwb_d;
            fault_q <= fault_d;
        end
    end

    assign pcSrc          = exm_q.branch & exm_q.zero;
    assign branchTarget   = exm_q.addResult;
    assign exMemRegWrite  = exm_q.regWrite;
    assign exMemWriteReg  = exm_q.writeReg;
    assign exMemAluResult = exm_q.aluResult;
    assign readData       = mwb_q.readData;
    assign wbAluResult    = mwb_q.aluResult;
    assign wbWriteReg     = mwb_q.writeReg;
    assign wbRegWrite     = mwb_q.regWrite;
    assign wbMemToReg     = mwb_q.memToReg;
    assign memFault       = fault_q;

endmodule

// File: tb/tb_memory_step.sv
// Scoreboard bench for memory_step: directed stimulus queues expectations,
// a negedge monitor retires them on their due cycle.
module tb_memory_step;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush;
    logic        memRead, memWrite, branch, regWrite, memToReg;
    logic [31:0] addResult;
    logic        zero;
    logic [31:0] aluResult, reg2Out;
    logic [4:0]  muxRegDstOut;
    logic        pcSrc;
    logic [31:0] branchTarget;
    logic        exMemRegWrite;
    logic [4:0]  exMemWriteReg;
    logic [31:0] exMemAluResult;
    logic [31:0] readData, wbAluResult;
    logic [4:0]  wbWriteReg;
    logic        wbRegWrite, wbMemToReg, memFault;

    memory_step #(.MEM_DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .memRead(memRead), .memWrite(memWrite), .branch(branch),
        .regWrite(regWrite), .memToReg(memToReg),
        .addResult(addResult), .zero(zero), .aluResult(aluResult),
        .reg2Out(reg2Out), .muxRegDstOut(muxRegDstOut),
        .pcSrc(pcSrc), .branchTarget(branchTarget),
        .exMemRegWrite(exMemRegWrite), .exMemWriteReg(exMemWriteReg),
        .exMemAluResult(exMemAluResult), .readData(readData),
        .wbAluResult(wbAluResult), .wbWriteReg(wbWriteReg),
        .wbRegWrite(wbRegWrite), .wbMemToReg(wbMemToReg),
        .memFault(memFault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int K_EX = 0;
    localparam int K_WB = 1;
    localparam int K_FLT = 2;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  r;
        logic        c1;
        logic        c2;
    } chk_t;

    chk_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic push(input chk_t e);
        int pos;
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].due > e.due) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    task automatic exp_ex(input int due, input logic pc, input logic [31:0] bt,
                          input logic [31:0] alu, input logic [4:0] wr,
                          input logic rw);
        chk_t e;
        e.due = due; e.kind = K_EX; e.a = bt; e.b = alu;
        e.r = wr; e.c1 = pc; e.c2 = rw;
        push(e);
    endtask

    task automatic exp_wb(input int due, input logic [31:0] rd,
                          input logic [31:0] alu, input logic [4:0] wr,
                          input logic rw, input logic m2r);
        chk_t e;
        e.due = due; e.kind = K_WB; e.a = rd; e.b = alu;
        e.r = wr; e.c1 = rw; e.c2 = m2r;
        push(e);
    endtask

    task automatic exp_flt(input int due, input logic f);
        chk_t e;
        e.due = due; e.kind = K_FLT; e.a = '0; e.b = '0;
        e.r = '0; e.c1 = f; e.c2 = 1'b0;
        push(e);
    endtask

    always @(negedge clk) begin
        chk_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            if (e.due < cyc) begin
                n_bad++;
                $display("FAIL overdue kind=%0d due=%0d now=%0d", e.kind, e.due, cyc);
            end else if (e.kind == K_EX) begin
                if (pcSrc !== e.c1 || branchTarget !== e.a ||
                    exMemAluResult !== e.b || exMemWriteReg !== e.r ||
                    exMemRegWrite !== e.c2) begin
                    n_bad++;
                    $display("FAIL exmem cyc=%0d got pc=%b bt=%h alu=%h wr=%0d rw=%b want pc=%b bt=%h alu=%h wr=%0d rw=%b",
                             cyc, pcSrc, branchTarget, exMemAluResult, exMemWriteReg,
                             exMemRegWrite, e.c1, e.a, e.b, e.r, e.c2);
                end
            end else if (e.kind == K_WB) begin
                if (readData !== e.a || wbAluResult !== e.b ||
                    wbWriteReg !== e.r || wbRegWrite !== e.c1 ||
                    wbMemToReg !== e.c2) begin
                    n_bad++;
                    $display("FAIL memwb cyc=%0d got rd=%h alu=%h wr=%0d rw=%b m2r=%b want rd=%h alu=%h wr=%0d rw=%b m2r=%b",
                             cyc, readData, wbAluResult, wbWriteReg, wbRegWrite,
                             wbMemToReg, e.a, e.b, e.r, e.c1, e.c2);
                end
            end else begin
                if (memFault !== e.c1) begin
                    n_bad++;
                    $display("FAIL memFault cyc=%0d got %b want %b", cyc, memFault, e.c1);
                end
            end
        end
    end

    task automatic check_all_zero(input string nm);
        n_cmp++;
        if (pcSrc !== 1'b0 || branchTarget !== '0 || exMemRegWrite !== 1'b0 ||
            exMemWriteReg !== '0 || exMemAluResult !== '0 || readData !== '0 ||
            wbAluResult !== '0 || wbWriteReg !== '0 || wbRegWrite !== 1'b0 ||
            wbMemToReg !== 1'b0 || memFault !== 1'b0) begin
            n_bad++;
            $display("FAIL %s got pc=%b bt=%h rd=%h wbalu=%h wr=%0d flt=%b want all 0",
                     nm, pcSrc, branchTarget, readData, wbAluResult, wbWriteReg, memFault);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic b,
                         input logic rw, input logic m2r, input logic [31:0] add,
                         input logic z, input logic [31:0] alu, input logic [31:0] d,
                         input logic [4:0] dst, input logic st, input logic fl);
        memRead = r; memWrite = w; branch = b; regWrite = rw; memToReg = m2r;
        addResult = add; zero = z; aluResult = alu; reg2Out = d;
        muxRegDstOut = dst; stall = st; flush = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        drive(0, 1, 0, 0, 0, 0, 0, a, d, 0, 0, 0);
    endtask

    task automatic ld(input logic [31:0] a, input logic [4:0] dst);
        drive(1, 0, 0, 1, 1, 0, 0, a, 0, dst, 0, 0);
    endtask

    int c;

    initial begin
        reset = 1'b0;
        stall = 0; flush = 0; memRead = 0; memWrite = 0; branch = 0;
        regWrite = 0; memToReg = 0; addResult = 0; zero = 0;
        aluResult = 0; reg2Out = 0; muxRegDstOut = 0;
        #1;
        check_all_zero("reset_initial");
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset_held");
        reset = 1'b1;

        // store then load same word
        c = cyc;
        exp_ex(c + 1, 0, 0, 32'h10, 0, 0);
        exp_wb(c + 2, 0, 32'h10, 0, 0, 0);
        exp_flt(c + 2, 0);
        st(32'h10, 32'hDEADBEEF);
        c = cyc;
        exp_ex(c + 1, 0, 0, 32'h10, 5, 1);
        exp_wb(c + 2, 32'hDEADBEEF, 32'h10, 5, 1, 1);
        ld(32'h10, 5);

        // branch taken / not taken
        c = cyc;
        exp_ex(c + 1, 1, 32'h40, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 32'h40, 1, 0, 0, 0, 0, 0);
        c = cyc;
        exp_ex(c + 1, 0, 32'h80, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 32'h80, 0, 0, 0, 0, 0, 0);

        // flush squashes a store
        st(32'h20, 32'h11111111);
        c = cyc;
        exp_ex(c + 1, 0, 0, 0, 0, 0);
        exp_wb(c + 2, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 32'h44, 1, 32'h20, 32'h1234, 3, 0, 1);
        c = cyc;
        exp_wb(c + 2, 32'h11111111, 32'h20, 7, 1, 1);
        ld(32'h20, 7);

        // stall for 3 cycles behind a store
        c = cyc;
        for (int i = 1; i <= 4; i++)
            exp_wb(c + i, 32'h11111111, 32'h20, 7, 1, 1);
        exp_ex(c + 4, 0, 0, 32'h8, 0, 0);
        exp_wb(c + 5, 0, 32'h8, 0, 0, 0);
        exp_wb(c + 7, 32'hA5A5A5A5, 32'h8, 9, 1, 1);
        st(32'h8, 32'hA5A5A5A5);
        repeat (3) drive(0, 1, 0, 0, 0, 0, 0, 32'h8, 32'hFFFFFFFF, 0, 1, 0);
        nop();
        ld(32'h8, 9);

        // flush and stall together
        c = cyc;
        exp_wb(c + 2, 0, 32'h55, 4, 1, 0);
        exp_ex(c + 3, 0, 0, 0, 0, 0);
        exp_wb(c + 3, 0, 32'h55, 4, 1, 0);
        exp_wb(c + 4, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 32'h55, 0, 4, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 32'h99, 0, 3, 0, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 32'h77, 0, 6, 1, 1);
        nop();

        // read-before-write on a combined access
        c = cyc;
        exp_wb(c + 2, 32'hDEADBEEF, 32'h10, 1, 1, 1);
        exp_wb(c + 3, 32'h00000005, 32'h10, 2, 1, 1);
        drive(1, 1, 0, 1, 1, 0, 0, 32'h10, 32'h5, 1, 0, 0);
        ld(32'h10, 2);

        // misaligned load, sticky fault, address wrap
        c = cyc;
        exp_flt(c + 1, 0);
        exp_wb(c + 2, 0, 32'h13, 6, 1, 1);
        exp_flt(c + 2, 1);
        exp_flt(c + 4, 1);
        exp_wb(c + 5, 32'hCAFEF00D, 32'h0, 2, 1, 1);
        exp_flt(c + 5, 1);
        ld(32'h13, 6);
        nop();
        st(32'h400, 32'hCAFEF00D);
        ld(32'h0, 2);
        nop();
        nop();
        nop();

        // async reset with a store in flight
        st(32'h10, 32'hBAD0BAD0);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("reset_async");
        @(negedge clk);
        #1;
        check_all_zero("reset_hold2");
        reset = 1'b1;
        c = cyc;
        exp_wb(c + 2, 32'h00000005, 32'h10, 8, 1, 1);
        exp_flt(c + 2, 0);
        ld(32'h10, 8);
        nop();

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_step.md
# memory_step

Fourth pipeline stage of the MIPS datapath: the consumer of the execute stage's outputs. It latches the execute results into an EX/MEM register and resolves branches from that register. It performs the data-memory load or store against an internal word RAM and presents a registered MEM/WB bundle to the write-back stage. Stall and flush inputs from the hazard unit freeze the stage or insert a bubble.

## Interface
- `MEM_DEPTH`, 256: number of 32-bit data words; power of two.
- `ADDR_W`, 8: log2(`MEM_DEPTH`).
- `clk`, in, 1: rising-edge clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `stall`, in, 1: freeze the whole stage this cycle.
- `flush`, in, 1: load a bubble into EX/MEM at this edge.
- `memRead`, `memWrite`, `branch`, `regWrite`, `memToReg`, in, 1 each: control from execute.
- `addResult`, in, 32: branch target from execute.
- `zero`, in, 1: ALU zero flag.
- `aluResult`, in, 32: ALU result, which is also the byte address.
- `reg2Out`, in, 32: store data.
- `muxRegDstOut`, in, 5: destination register.
- `pcSrc`, out, 1: take the branch.
- `branchTarget`, out, 32: registered `addResult`.
- `exMemRegWrite`, out, 1: EX/MEM `regWrite`, for forwarding.
- `exMemWriteReg`, out, 5: EX/MEM destination register, for forwarding.
- `exMemAluResult`, out, 32: EX/MEM ALU result, for forwarding.
- `readData`, out, 32: MEM/WB load data.
- `wbAluResult`, out, 32: MEM/WB ALU result.
- `wbWriteReg`, out, 5: MEM/WB destination register.
- `wbRegWrite`, out, 1: MEM/WB control.
- `wbMemToReg`, out, 1: MEM/WB control.
- `memFault`, out, 1: sticky misaligned-access flag.

## Operation
**EX/MEM register**
- All EX-side inputs are captured at the rising edge.
- Priority at each edge: `flush` > `stall` > normal capture.
- On `flush`: all five control bits are cleared (bubble). Data fields are don't-care; the implementation loads 0.
- On `stall` without `flush`: the register holds its contents.

**Branch resolution (combinational from EX/MEM)**
- `pcSrc` = EX/MEM `branch` & EX/MEM `zero`.
- `branchTarget` = EX/MEM `addResult`.

**Memory access**
- Word index = EX/MEM `aluResult[ADDR_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo `MEM_DEPTH`*4.
- Misaligned access: EX/MEM `aluResult[1:0]` != 0 while `memRead` or `memWrite` is set.
  - The store is suppressed.
  - The load returns 32'h0.
  - `memFault` is set and stays set until reset.
- Store: `mem[index]` <= EX/MEM `reg2Out` at the rising edge ending the MEM cycle. It requires `memWrite`, no `stall`, and aligned access. Each instruction writes exactly once.
- `memRead` and `memWrite` both set: the store takes effect and `readData` returns the old word (read-before-write).
- Load data is captured directly into MEM/WB `readData`. When `memRead`=0, `readData` loads 0.
- RAM contents are not reset.

**MEM/WB register**
- Captures the EX/MEM `regWrite`, `memToReg`, `aluResult` and `writeReg` fields, plus the load data.
- On `stall`: holds. `flush` does not affect MEM/WB.

## Timing
- Reset asserted (low): every EX/MEM and MEM/WB field and `memFault` clear to 0 immediately.
  - Consequence: `pcSrc`=0, `branchTarget`=0, every `wb*` output = 0, `readData`=0.
- Reset mid-operation: an in-flight store at the reset edge is not performed.
- Inputs sampled at edge N:
  - `pcSrc`, `branchTarget` and the `exMem*` outputs are valid after edge N.
  - The memory write and the MEM/WB outputs take effect at edge N+1, so load-to-output latency is 2 edges.
- Back-to-back store then load to the same address: the load in the next cycle returns the new data.
- Stall held for k cycles: outputs are frozen for k cycles and no duplicate write occurs.
- `flush` together with `stall` at the same edge: the bubble is loaded into EX/MEM and MEM/WB holds.

## Test plan
- **Reset:** assert `reset`=0 mid-stream → all outputs 0 asynchronously, before the next `clk` edge.
- **Store then load:**
  - Edge 1: store `aluResult`=0x10, `reg2Out`=0xDEADBEEF.
  - Edge 2: load 0x10 with `memToReg`=1, `regWrite`=1, dest=5.
  - Required: after edge 3, `readData`=0xDEADBEEF, `wbWriteReg`=5, `wbMemToReg`=1.
- **Branch:** `branch`=1, `zero`=1, `addResult`=0x40 → `pcSrc`=1 and `branchTarget`=0x40 after one edge. With `zero`=0 → `pcSrc`=0.
- **Flush:** `flush`=1 on a `memWrite` instruction to 0x20 holding 0x1234 → location 0x20 keeps its prior value, `exMemRegWrite`=0, `pcSrc`=0.
- **Stall:** a store to 0x8 of 0xA5A5A5A5 is followed by `stall` for 3 cycles; a different value is driven at `reg2Out` during the stall → memory holds 0xA5A5A5A5 and `wb*` outputs stay unchanged during the stall.
- **Misaligned and wrap:**
  - Load 0x13 → `readData`=0, `memFault`=1, and the flag stays 1 through later aligned accesses.
  - Store to 0x400 with depth 256 → aliases to word 0 (read back at 0x0).
